pwm_ramp_gen: RTL and testbench

- Digital PWM transmitter that drives the PWM input of the analog RC filter model in the pwm_ramp IP.
- Generates a fixed-period PWM waveform.
- Moves its duty cycle toward a handshaked target in programmable steps, one step every N periods, so the filtered voltage ramps instead of jumping.
- Duty and period updates take effect only at period boundaries, so the output never glitches.

---
 rtl/pwm_ramp_gen.sv | 158 +++++++++++++++
 tb/tb_pwm_ramp_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_gen.sv
// Fixed-period PWM transmitter whose duty ramps toward a handshaked target in steps.
// Define PWM_RAMP_COMPL_EN to add the dead-time complementary output pwm_n_o.
module pwm_ramp_gen #(
   parameter int CNT_W = 8,
   parameter int DIV_W = 8
`ifdef PWM_RAMP_COMPL_EN
   ,
   parameter int DEADTIME = 2
`endif
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic [CNT_W-1:0] step_i,
   input  logic [DIV_W-1:0] ramp_div_i,
   input  logic [CNT_W-1:0] target_i,
   input  logic             target_valid_i,
   output logic             target_ready_o,
   output logic             pwm_o,
   output logic [CNT_W-1:0] duty_o,
   output logic             period_end_o,
   output logic             ramp_done_o,
   output logic             busy_o
`ifdef PWM_RAMP_COMPL_EN
   ,
   output logic             pwm_n_o
`endif
);

   typedef enum logic [1:0] {IDLE, HOLD, RAMP_UP, RAMP_DOWN} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] duty_cur;
   logic [CNT_W-1:0] duty_tgt;
   logic [CNT_W-1:0] period_q;
   logic [DIV_W-1:0] tick;

   logic             accept;
   logic             wrap;
   logic [CNT_W-1:0] tgt_next;
   logic [CNT_W:0]   step_eff;
   logic [CNT_W-1:0] duty_up;
   logic [CNT_W-1:0] duty_dn;
   logic [CNT_W-1:0] duty_step;

   assign target_ready_o = (state == IDLE) || (state == HOLD);
   assign busy_o         = (state == RAMP_UP) || (state == RAMP_DOWN);
   assign duty_o         = duty_cur;
   assign accept         = target_valid_i && target_ready_o;
   assign wrap           = (cnt == period_q);
   assign tgt_next       = accept ? target_i : duty_tgt;

   // Clamp against the target in CNT_W+1 bits so a large step can never wrap.
   always_comb begin
      step_eff = (step_i == '0) ? (CNT_W+1)'(1) : {1'b0, step_i};
      if (({1'b0, duty_cur} + step_eff) >= {1'b0, duty_tgt})
         duty_up = duty_tgt;
      else
         duty_up = duty_cur + step_eff[CNT_W-1:0];
      if ({1'b0, duty_cur} < (step_eff + {1'b0, duty_tgt}))
         duty_dn = duty_tgt;
      else
         duty_dn = duty_cur - step_eff[CNT_W-1:0];
      duty_step = (state == RAMP_DOWN) ? duty_dn : duty_up;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         cnt          <= '0;
         duty_cur     <= '0;
         duty_tgt     <= '0;
         period_q     <= '0;
         tick         <= '0;
         pwm_o        <= 1'b0;
         period_end_o <= 1'b0;
         ramp_done_o  <= 1'b0;
      end else begin
         period_end_o <= 1'b0;
         ramp_done_o  <= 1'b0;
         if (accept)
            duty_tgt <= target_i;
         if (!en_i) begin
            state <= IDLE;
            cnt   <= '0;
            tick  <= '0;
            pwm_o <= 1'b0;
         end else begin
            pwm_o <= (state != IDLE) && (cnt < duty_cur);
            if (state != IDLE) begin
               if (wrap) begin
                  cnt          <= '0;
                  period_q     <= period_i;
                  period_end_o <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            case (state)
               IDLE: begin
                  if (tgt_next > duty_cur)
                     state <= RAMP_UP;
                  else if (tgt_next < duty_cur)
                     state <= RAMP_DOWN;
                  else
                     state <= HOLD;
               end
               HOLD: begin
                  if (accept) begin
                     if (target_i > duty_cur)
                        state <= RAMP_UP;
                     else if (target_i < duty_cur)
                        state <= RAMP_DOWN;
                     else
                        ramp_done_o <= 1'b1;
                  end
               end
               RAMP_UP, RAMP_DOWN: begin
                  if (wrap) begin
                     if (tick == ramp_div_i) begin
                        tick     <= '0;
                        duty_cur <= duty_step;
                        if (duty_step == duty_tgt) begin
                           ramp_done_o <= 1'b1;
                           state       <= HOLD;
                        end
                     end else begin
                        tick <= tick + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef PWM_RAMP_COMPL_EN
   // pwm_n_o shares pwm_o's one-cycle latency from cnt; its high window is shrunk by
   // DEADTIME on both sides, leaving the gap before pwm_o rises at the next wrap too.
   logic [CNT_W+1:0] cnt_x;
   logic [CNT_W+1:0] dt_x;
   assign cnt_x = {2'b00, cnt};
   assign dt_x  = (CNT_W+2)'(DEADTIME);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         pwm_n_o <= 1'b0;
      else
         pwm_n_o <= en_i && (state != IDLE)
                    && (cnt_x >= ({2'b00, duty_cur} + dt_x))
                    && ((cnt_x + dt_x) <= {2'b00, period_q});
   end
`endif

endmodule

// File: tb/tb_pwm_ramp_gen.sv
// Self-checking bench for pwm_ramp_gen: directed and randomized ramps against a
// step-sequence model and per-period high-count arithmetic.
module tb_pwm_ramp_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] period;
   logic [7:0] step;
   logic [7:0] ramp_div;
   logic [7:0] target;
   logic       target_valid;
   logic       target_ready;
   logic       pwm;
   logic [7:0] duty;
   logic       period_end;
   logic       ramp_done;
   logic       busy;
`ifdef PWM_RAMP_COMPL_EN
   logic       pwm_n;
`endif

   int n_pass = 0;
   int n_chk  = 0;
   int m_duty = 0;

   pwm_ramp_gen #(.CNT_W(8), .DIV_W(8)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .en_i           (en),
      .period_i       (period),
      .step_i         (step),
      .ramp_div_i     (ramp_div),
      .target_i       (target),
      .target_valid_i (target_valid),
      .target_ready_o (target_ready),
      .pwm_o          (pwm),
      .duty_o         (duty),
      .period_end_o   (period_end),
      .ramp_done_o    (ramp_done),
      .busy_o         (busy)
`ifdef PWM_RAMP_COMPL_EN
      ,
      .pwm_n_o        (pwm_n)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pe();
      int n = 0;
      do begin
         cyc();
         n++;
      end while (!period_end && n < 600);
      if (!period_end) chk("period_end_timeout", 0, 1);
   endtask

   // Starts at a period_end sample; samples through the next one.
   task automatic measure(input int exp_len, input int chg_at, input int chg_val,
                          input string tag, output int both_low, output int n_high);
      int d   = int'(duty);
      int len = 0;
      int hi  = 0;
      int ovl = 0;
      both_low = 0;
      n_high   = 0;
      do begin
         cyc();
         len++;
         if (pwm) hi++;
`ifdef PWM_RAMP_COMPL_EN
         if (pwm && pwm_n) ovl++;
         if (!pwm && !pwm_n) both_low++;
         if (pwm_n) n_high++;
`endif
         if (len == chg_at) period = 8'(chg_val);
      end while (!period_end && len < 600);
      chk({tag, "_len"}, len, exp_len);
      chk({tag, "_high"}, hi, (d < exp_len) ? d : exp_len);
`ifdef PWM_RAMP_COMPL_EN
      chk({tag, "_overlap"}, ovl, 0);
`endif
   endtask

   // Model: list of duties applied at each ramp tick, one tick every div+1 periods.
   task automatic follow(input int start, input int tgt, input int s, input int div);
      int seq[$];
      int d      = start;
      int se     = (s == 0) ? 1 : s;
      int pe     = 0;
      int idx    = 0;
      int budget = 0;
      int prev   = start;
      while (d != tgt) begin
         if (tgt > d) d = (d + se > tgt) ? tgt : d + se;
         else         d = (d - se < tgt) ? tgt : d - se;
         seq.push_back(d);
      end
      while (idx < seq.size() && budget < 20000) begin
         cyc();
         budget++;
         if (period_end) begin
            pe++;
            if (pe % (div + 1) == 0) begin
               chk("ramp_duty", duty, seq[idx]);
               chk("ramp_done", ramp_done, idx == seq.size() - 1);
               chk("ramp_busy", busy, idx != seq.size() - 1);
               chk("ramp_ready", target_ready, idx == seq.size() - 1);
               prev = seq[idx];
               idx++;
            end else begin
               chk("ramp_hold_duty", duty, prev);
            end
         end else if (ramp_done) begin
            chk("ramp_done_stray", ramp_done, 0);
         end
      end
      if (idx < seq.size()) chk("ramp_timeout", idx, seq.size());
      m_duty = tgt;
   endtask

   task automatic offer(input int t, input int s, input int div);
      int n = 0;
      step     = 8'(s);
      ramp_div = 8'(div);
      while (!target_ready && n < 2000) begin
         cyc();
         n++;
      end
      if (!target_ready) chk("ready_timeout", 0, 1);
      target       = 8'(t);
      target_valid = 1'b1;
      cyc();
      target_valid = 1'b0;
      if (t == m_duty) begin
         chk("eq_done", ramp_done, 1);
         chk("eq_busy", busy, 0);
         cyc();
         chk("eq_done_clear", ramp_done, 0);
         chk("eq_busy_after", busy, 0);
      end else begin
         chk("accept_busy", busy, 1);
         chk("accept_ready", target_ready, 0);
         follow(m_duty, t, s, div);
      end
   endtask

   initial begin
      int bl, nh, p, t, s, dv;
      rst = 1'b1; en = 1'b0; period = 8'd9; step = 8'd1; ramp_div = 8'd0;
      target = 8'd0; target_valid = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      chk("rst_pwm", pwm, 0);
      chk("rst_duty", duty, 0);
      chk("rst_ready", target_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_pe", period_end, 0);
      chk("rst_done", ramp_done, 0);
`ifdef PWM_RAMP_COMPL_EN
      chk("rst_pwm_n", pwm_n, 0);
`endif
      en = 1'b1;
      cyc();
      cyc();

      // Ramp up 0 -> 10 by 3 every period, then 100% duty.
      offer(10, 3, 0);
      wait_pe();
      measure(10, -1, 0, "full_duty", bl, nh);

      // Ramp down with divider.
      offer(8, 2, 0);
      offer(2, 4, 1);
      offer(2, 1, 0);

      // Target held valid through a ramp is taken only once back in HOLD.
      step = 8'd2; ramp_div = 8'd0;
      target = 8'd12; target_valid = 1'b1;
      cyc();
      target = 8'd5;
      chk("stall_busy", busy, 1);
      follow(2, 12, 2, 0);
      chk("stall_duty_kept", duty, 12);
      cyc();
      target_valid = 1'b0;
      chk("stall_accept_busy", busy, 1);
      follow(12, 5, 2, 0);

      // Period change mid-period at cnt=5.
      offer(3, 2, 0);
      wait_pe();
      measure(10, 5, 4, "per_chg_old", bl, nh);
      measure(5, -1, 0, "per_chg_new", bl, nh);

      // Disable: output parked low, duty kept.
      en = 1'b0;
      cyc();
      chk("idle_duty", duty, 3);
      chk("idle_ready", target_ready, 1);
      chk("idle_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
         chk("idle_pwm", pwm, 0);
`ifdef PWM_RAMP_COMPL_EN
         chk("idle_pwm_n", pwm_n, 0);
`endif
         cyc();
      end
      en = 1'b1;
      period = 8'd9;
      cyc();
      cyc();

      // Clamp without underflow / overflow.
      offer(0, 5, 0);
      wait_pe();
      measure(10, -1, 0, "zero_duty", bl, nh);
      offer(255, 200, 0);
      wait_pe();
      measure(10, -1, 0, "max_duty", bl, nh);
      offer(5, 250, 0);
      wait_pe();
      measure(10, -1, 0, "duty5", bl, nh);
`ifdef PWM_RAMP_COMPL_EN
      chk("dead_both_low", bl, 4);
      chk("compl_high", nh, 1);
`endif

      // Randomized ramps with per-period duty check.
      for (int k = 0; k < 8; k++) begin
         p  = int'($urandom_range(3, 12));
         t  = int'($urandom_range(0, 30));
         s  = int'($urandom_range(0, 6));
         dv = int'($urandom_range(0, 2));
         period = 8'(p);
         offer(t, s, dv);
         wait_pe();
         measure(p + 1, -1, 0, "rand_period", bl, nh);
      end

      // Reset in the middle of a ramp.
      period = 8'd9; step = 8'd1; ramp_div = 8'd2;
      target = 8'd200; target_valid = 1'b1;
      cyc();
      target_valid = 1'b0;
      repeat (45) cyc();
      chk("mid_ramp_busy", busy, 1);
      rst = 1'b1;
      cyc();
      chk("midrst_pwm", pwm, 0);
      chk("midrst_duty", duty, 0);
      chk("midrst_ready", target_ready, 1);
      chk("midrst_busy", busy, 0);
      rst = 1'b0;
      m_duty = 0;
      cyc();
      cyc();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_duty", duty, 0);
      offer(4, 2, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
